vector_pair_scheduler: RTL and testbench

- Sequences one shared synchronous single-port element RAM to build operand vector pairs (A, B) for the downstream vector multiplier.
- Per pair: fetches VECTOR_DIMENSION contiguous elements of A, then VECTOR_DIMENSION contiguous elements of B, then presents both vectors under a valid/ready handshake.
- Repeats for pair_count pairs, then pulses done. Sits between element RAM and the multiply datapath, replacing free-running vector construction with controlled, paired fetches.

---
 rtl/vector_pair_scheduler_if.sv | 24 ++
 rtl/vector_pair_scheduler.sv | 149 ++++++++++++++
 tb/tb_vector_pair_scheduler.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_pair_scheduler_if.sv
// rtl/vector_pair_scheduler_if.sv - RAM read port and paired-vector output handshake
interface vector_pair_scheduler_if #(
    parameter int ELEMENT_WIDTH    = 24,
    parameter int ADDR_WIDTH       = 17,
    parameter int VECTOR_DIMENSION = 3
);
    logic [ADDR_WIDTH-1:0]    ram_addr;
    logic                     ram_en;
    logic [ELEMENT_WIDTH-1:0] ram_data;
    logic [ELEMENT_WIDTH-1:0] vec_a [0:VECTOR_DIMENSION-1];
    logic [ELEMENT_WIDTH-1:0] vec_b [0:VECTOR_DIMENSION-1];
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output ram_addr, ram_en, vec_a, vec_b, out_valid,
        input  ram_data, out_ready
    );

    modport slave (
        input  ram_addr, ram_en, vec_a, vec_b, out_valid,
        output ram_data, out_ready
    );
endinterface

// File: rtl/vector_pair_scheduler.sv
// rtl/vector_pair_scheduler.sv - fetches A then B vectors from one RAM and presents them as a pair
module vector_pair_scheduler #(
    parameter int ELEMENT_WIDTH    = 24,
    parameter int ADDR_WIDTH       = 17,
    parameter int VECTOR_DIMENSION = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_a,
    input  logic [ADDR_WIDTH-1:0]    base_b,
    input  logic [ELEMENT_WIDTH-1:0] pair_count,
    vector_pair_scheduler_if.master  bus,
    output logic                     busy,
    output logic [ELEMENT_WIDTH-1:0] pairs_done,
    output logic                     done
);
    localparam int KW = (VECTOR_DIMENSION > 1) ? $clog2(VECTOR_DIMENSION) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(VECTOR_DIMENSION - 1);

    typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, DRAIN, PRESENT, FINISH} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d;
    logic [ADDR_WIDTH-1:0]    last_addr_q, last_addr_d;
    logic [KW-1:0]            k_q, k_d;
    logic [ELEMENT_WIDTH-1:0] count_q, count_d, pairs_done_q, pairs_done_d;
    logic                     out_valid_q, out_valid_d;
    logic                     cap_valid_q, cap_valid_d, cap_b_q, cap_b_d;
    logic [KW-1:0]            cap_idx_q, cap_idx_d;
    logic [ELEMENT_WIDTH-1:0] vec_a_q [0:VECTOR_DIMENSION-1];
    logic [ELEMENT_WIDTH-1:0] vec_b_q [0:VECTOR_DIMENSION-1];
    logic                     ram_en;
    logic [ADDR_WIDTH-1:0]    ram_addr;

    always_comb begin
        state_d      = state_q;
        a_ptr_d      = a_ptr_q;
        b_ptr_d      = b_ptr_q;
        last_addr_d  = last_addr_q;
        k_d          = k_q;
        count_d      = count_q;
        pairs_done_d = pairs_done_q;
        out_valid_d  = out_valid_q;
        cap_valid_d  = 1'b0;
        cap_b_d      = 1'b0;
        cap_idx_d    = k_q;
        ram_en       = 1'b0;
        ram_addr     = last_addr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_ptr_d      = base_a;
                    b_ptr_d      = base_b;
                    count_d      = pair_count;
                    pairs_done_d = '0;
                    k_d          = '0;
                    state_d      = (pair_count == '0) ? FINISH : FETCH_A;
                end
            end
            FETCH_A: begin
                ram_en      = 1'b1;
                ram_addr    = a_ptr_q;
                last_addr_d = a_ptr_q;
                a_ptr_d     = a_ptr_q + ADDR_WIDTH'(1);
                cap_valid_d = 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = FETCH_B;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            FETCH_B: begin
                ram_en      = 1'b1;
                ram_addr    = b_ptr_q;
                last_addr_d = b_ptr_q;
                b_ptr_d     = b_ptr_q + ADDR_WIDTH'(1);
                cap_valid_d = 1'b1;
                cap_b_d     = 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
                out_valid_d = 1'b1;
                state_d     = PRESENT;
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    out_valid_d  = 1'b0;
                    pairs_done_d = pairs_done_q + ELEMENT_WIDTH'(1);
                    state_d = (pairs_done_q + ELEMENT_WIDTH'(1) == count_q) ? FINISH : FETCH_A;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data lands one cycle after its address, so slot selection trails the fetch by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            a_ptr_q      <= '0;
            b_ptr_q      <= '0;
            last_addr_q  <= '0;
            k_q          <= '0;
            count_q      <= '0;
            pairs_done_q <= '0;
            out_valid_q  <= 1'b0;
            cap_valid_q  <= 1'b0;
            cap_b_q      <= 1'b0;
            cap_idx_q    <= '0;
            for (int i = 0; i < VECTOR_DIMENSION; i++) begin
                vec_a_q[i] <= '0;
                vec_b_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            a_ptr_q      <= a_ptr_d;
            b_ptr_q      <= b_ptr_d;
            last_addr_q  <= last_addr_d;
            k_q          <= k_d;
            count_q      <= count_d;
            pairs_done_q <= pairs_done_d;
            out_valid_q  <= out_valid_d;
            cap_valid_q  <= cap_valid_d;
            cap_b_q      <= cap_b_d;
            cap_idx_q    <= cap_idx_d;
            if (cap_valid_q) begin
                if (cap_b_q) vec_b_q[cap_idx_q] <= bus.ram_data;
                else         vec_a_q[cap_idx_q] <= bus.ram_data;
            end
        end
    end

    assign bus.ram_en    = ram_en;
    assign bus.ram_addr  = ram_addr;
    assign bus.vec_a     = vec_a_q;
    assign bus.vec_b     = vec_b_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == FINISH);
    assign pairs_done    = pairs_done_q;
endmodule

// File: tb/tb_vector_pair_scheduler.sv
// tb/tb_vector_pair_scheduler.sv - randomized self-checking bench with a behavioural pair model
module tb_vector_pair_scheduler;
    localparam int EW = 24;
    localparam int AW = 17;
    localparam int N  = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_PRES = 2, M_FIN = 3;

    logic          clk, reset, start, out_ready, busy, done;
    logic [AW-1:0] base_a, base_b;
    logic [EW-1:0] pair_count, pairs_done;

    vector_pair_scheduler_if #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .VECTOR_DIMENSION(N)) bus ();
    assign bus.out_ready = out_ready;

    vector_pair_scheduler #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .VECTOR_DIMENSION(N)) dut (
        .clk(clk), .reset(reset), .start(start), .base_a(base_a), .base_b(base_b),
        .pair_count(pair_count), .bus(bus), .busy(busy), .pairs_done(pairs_done), .done(done)
    );

    int checks = 0;
    int errs   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [EW-1:0] mem [int];

    function automatic logic [EW-1:0] rd(input logic [AW-1:0] a);
        logic [31:0] h;
        if (mem.exists(int'(a))) return mem[int'(a)];
        h = {15'd0, a} * 32'h9E3779B1;
        return h[30:7];
    endfunction

    always @(posedge clk) if (bus.ram_en) bus.ram_data <= rd(bus.ram_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: pair p reads base+p*N+i, fetch+drain spans 2N+1 cycles, then presents.
    int            m_mode = M_IDLE, m_ph = 0, m_p = 0, m_pd = 0, m_cnt = 0;
    bit            m_live = 1'b0;
    logic [AW-1:0] m_ba = '0, m_bb = '0, m_last = '0;

    function automatic logic [AW-1:0] maddr(input int ph);
        if (ph < N) return AW'(int'(m_ba) + m_p * N + ph);
        return AW'(int'(m_bb) + m_p * N + ph - N);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_live = 1'b1; m_mode = M_IDLE; m_pd = 0; m_last = '0;
        end else if (m_live) begin
            case (m_mode)
                M_IDLE: if (start) begin
                    m_ba = base_a; m_bb = base_b; m_cnt = int'(pair_count);
                    m_pd = 0; m_p = 0; m_ph = 0;
                    m_mode = (pair_count == '0) ? M_FIN : M_RUN;
                end
                M_RUN: if (m_ph < 2 * N) begin
                    m_last = maddr(m_ph); m_ph++;
                end else m_mode = M_PRES;
                M_PRES: if (out_ready) begin
                    m_pd++; m_p++; m_ph = 0;
                    m_mode = (m_pd == m_cnt) ? M_FIN : M_RUN;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    logic          exp_en;
    logic [AW-1:0] exp_addr;
    always @(negedge clk) if (m_live) begin
        exp_en   = (m_mode == M_RUN) && (m_ph < 2 * N);
        exp_addr = exp_en ? maddr(m_ph) : m_last;
        chk("ram_en", bus.ram_en, exp_en);
        chk("ram_addr", bus.ram_addr, exp_addr);
        chk("busy", busy, m_mode != M_IDLE);
        chk("done", done, m_mode == M_FIN);
        chk("out_valid", bus.out_valid, m_mode == M_PRES);
        chk("pairs_done", pairs_done, EW'(m_pd));
        if (m_mode == M_PRES)
            for (int i = 0; i < N; i++) begin
                chk("vec_a", bus.vec_a[i], rd(AW'(int'(m_ba) + m_p * N + i)));
                chk("vec_b", bus.vec_b[i], rd(AW'(int'(m_bb) + m_p * N + i)));
            end
    end

    logic [AW-1:0] addr_log [0:255];
    logic [EW-1:0] cap_a [0:N-1];
    logic [EW-1:0] cap_b [0:N-1];
    int nlog, valid_cyc, done_cyc, busy_cyc, hs, dn;

    // mode 0: ready always; 1: random ready and input churn; 2: 5-cycle stall on pair 2; 3: start while busy
    task automatic run_job(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                           input logic [EW-1:0] cnt, input int mode);
        int n, stall;
        bit fin;
        @(negedge clk);
        base_a = ba; base_b = bb; pair_count = cnt; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; stall = 5; fin = 1'b0;
        nlog = 0; valid_cyc = -1; done_cyc = -1; busy_cyc = 0; hs = 0; dn = 0;
        while (!fin && n < 400) begin
            if (bus.ram_en && nlog < 256) begin addr_log[nlog] = bus.ram_addr; nlog++; end
            if (bus.out_valid && valid_cyc < 0) begin
                valid_cyc = n;
                for (int i = 0; i < N; i++) begin cap_a[i] = bus.vec_a[i]; cap_b[i] = bus.vec_b[i]; end
            end
            if (busy) busy_cyc++;
            if (done) begin dn++; done_cyc = n; end
            case (mode)
                1: begin
                    out_ready  = ($urandom_range(0, 3) != 0);
                    base_a     = AW'($urandom);
                    base_b     = AW'($urandom);
                    pair_count = EW'($urandom_range(0, 7));
                end
                2: if (bus.out_valid && hs == 1 && stall > 0) begin
                    out_ready = 1'b0; stall--;
                end else out_ready = 1'b1;
                3: begin
                    out_ready = 1'b1;
                    if ((bus.out_valid && hs == 0) || done) begin
                        start = 1'b1; base_a = ba ^ 17'h155; base_b = bb + 17'd9; pair_count = cnt + 24'd5;
                    end else start = 1'b0;
                end
                default: out_ready = 1'b1;
            endcase
            if (bus.out_valid && out_ready) hs++;
            if (done) fin = 1'b1;
            else begin @(negedge clk); n++; end
        end
        if (!fin) begin
            errs++; checks++;
            $display("FAIL job_timeout: got no done expected done within 400 cycles");
        end
        @(negedge clk);
        start = 1'b0;
        chk("handshakes", hs, cnt);
        chk("done_pulses", dn, 1);
        chk("idle_after_done", busy, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int bad;
        logic [AW-1:0] ba;
        reset = 1'b1; start = 1'b0; base_a = '0; base_b = '0; pair_count = '0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin mem[10 + i] = EW'(i + 1); mem[40 + i] = EW'(i + 4); end
        repeat (3) @(negedge clk);
        chk("rst_ram_en", bus.ram_en, 1'b0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pairs_done", pairs_done, 0);
        chk("rst_vec_a0", bus.vec_a[0], 0);
        chk("rst_vec_b2", bus.vec_b[2], 0);
        reset = 1'b0;

        run_job(17'd10, 17'd40, 24'd1, 0);
        chk("basic_nlog", nlog, 6);
        chk("basic_a0", addr_log[0], 10); chk("basic_a2", addr_log[2], 12);
        chk("basic_b0", addr_log[3], 40); chk("basic_b2", addr_log[5], 42);
        chk("basic_valid_cyc", valid_cyc, 8);
        chk("basic_done_cyc", done_cyc, 9);
        chk("basic_vec_a", {cap_a[0], cap_a[1], cap_a[2]}, {24'd1, 24'd2, 24'd3});
        chk("basic_vec_b", {cap_b[0], cap_b[1], cap_b[2]}, {24'd4, 24'd5, 24'd6});
        chk("basic_pairs_done", pairs_done, 1);

        run_job(17'd10, 17'd40, 24'd3, 2);
        chk("multi_nlog", nlog, 18);
        chk("multi_p1_a0", addr_log[6], 13); chk("multi_p1_a2", addr_log[8], 15);
        chk("multi_p1_b0", addr_log[9], 43);
        chk("multi_p2_a0", addr_log[12], 16); chk("multi_p2_b2", addr_log[17], 48);
        chk("multi_pairs_done", pairs_done, 3);

        run_job(17'd0, 17'd0, 24'd0, 0);
        chk("zero_done_cyc", done_cyc, 1);
        chk("zero_busy_cyc", busy_cyc, 1);
        chk("zero_nlog", nlog, 0);
        chk("zero_no_valid", valid_cyc, -1);

        run_job(17'h1FFFE, 17'h1FFFF, 24'd2, 0);
        chk("wrap_a0", addr_log[0], 17'h1FFFE);
        chk("wrap_a1", addr_log[1], 17'h1FFFF);
        chk("wrap_a2", addr_log[2], 17'h00000);
        chk("wrap_b1", addr_log[4], 17'h00000);
        chk("wrap_p1_a0", addr_log[6], 17'h00001);

        @(negedge clk);
        base_a = 17'd200; base_b = 17'd300; pair_count = 24'd2; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstmid_addr", bus.ram_addr, 301);
        chk("rstmid_en", bus.ram_en, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_ram_en", bus.ram_en, 1'b0);
        chk("rstmid_valid", bus.out_valid, 1'b0);
        chk("rstmid_pairs_done", pairs_done, 0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_vec_a0", bus.vec_a[0], 0);
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || bus.ram_en || bus.out_valid) bad++;
        end
        chk("rstmid_quiet", bad, 0);
        run_job(17'd200, 17'd300, 24'd2, 0);

        run_job(17'd500, 17'd600, 24'd2, 3);
        chk("busy_start_p1_a0", addr_log[6], 503);
        chk("busy_start_p1_b0", addr_log[9], 603);
        chk("busy_start_pairs", pairs_done, 2);

        for (int j = 0; j < 25; j++) begin
            ba = ($urandom_range(0, 3) == 0) ? AW'(17'h1FFFF - $urandom_range(0, 6)) : AW'($urandom);
            run_job(ba, AW'($urandom), EW'($urandom_range(0, 4)), 1);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
